// File: rtl/round_key_add_col_pkg.sv
// Shared AES column types and round-key word helper.
package aes_pkg;

    localparam int COL_W  = 32;
    localparam int BLK_W  = 4 * COL_W;
    localparam int NR_128 = 10;

    typedef logic [COL_W-1:0] col_t;
    typedef logic [BLK_W-1:0] state_t;

    typedef enum logic {
        COLLECT,
        FULL
    } ark_state_e;

    // Word 0 sits in the most significant bits of the key.
    function automatic col_t key_word(input state_t k, input logic [1:0] idx);
        col_t w;
        case (idx)
            2'd0:    w = k[127:96];
            2'd1:    w = k[95:64];
            2'd2:    w = k[63:32];
            default: w = k[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/round_key_add_col_if.sv
// Column-in / state-out handshake bundle for the AddRoundKey stage.
interface round_key_add_col_if;
    import aes_pkg::*;

    col_t        i_Col_Data;
    logic        i_Col_Valid;
    logic        o_Col_Ready;
    state_t      i_Round_Key;
    state_t      o_Data;
    logic        o_Valid;
    logic        i_Ready;
    logic [3:0]  o_Round;
    logic        o_Last;

    modport slave (
        input  i_Col_Data, i_Col_Valid, i_Round_Key, i_Ready,
        output o_Col_Ready, o_Data, o_Valid, o_Round, o_Last
    );

    modport master (
        output i_Col_Data, i_Col_Valid, i_Round_Key, i_Ready,
        input  o_Col_Ready, o_Data, o_Valid, o_Round, o_Last
    );

endinterface

// File: rtl/round_key_add_col_ark_col_xor.sv
// Combinational column XOR with the round-key word selected by column index.
module ark_col_xor
    import aes_pkg::*;
(
    input  col_t       col,
    input  state_t     key,
    input  logic [1:0] idx,
    output col_t       keyed
);

    assign keyed = col ^ key_word(key, idx);

endmodule

// File: rtl/round_key_add_col.sv
// Column-serial AddRoundKey stage assembling a 128-bit keyed state.
// Optional round counter built when AES_ROUND_CNT_EN is defined.
module round_key_add_col
    import aes_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    round_key_add_col_if.slave bus
);

    ark_state_e       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    state_t           key_q;
    logic [3:0][31:0] slot_q;
    logic             rdy_en_q;
    logic             col_ready;
    logic             col_acc;
    logic             out_acc;
    state_t           key_sel;
    col_t             keyed;

    assign col_ready = rdy_en_q & ((state_q == COLLECT) | bus.i_Ready);
    assign col_acc   = bus.i_Col_Valid & col_ready;
    assign out_acc   = (state_q == FULL) & bus.i_Ready;

    // Column 0 keys straight from the input; later columns use the captured key.
    assign key_sel = (idx_q == 2'd0) ? bus.i_Round_Key : key_q;

    ark_col_xor u_xor (
        .col   (bus.i_Col_Data),
        .key   (key_sel),
        .idx   (idx_q),
        .keyed (keyed)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            COLLECT: begin
                if (col_acc) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = FULL;
                end
            end
            FULL: begin
                if (out_acc) begin
                    state_d = COLLECT;
                    if (col_acc) idx_d = 2'd1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            idx_q    <= 2'd0;
            key_q    <= '0;
            slot_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rdy_en_q <= 1'b1;
            if (col_acc) begin
                slot_q[idx_q] <= keyed;
                if (idx_q == 2'd0) key_q <= bus.i_Round_Key;
            end
        end
    end

    assign bus.o_Col_Ready = col_ready;
    assign bus.o_Valid     = (state_q == FULL);
    assign bus.o_Data      = {slot_q[0], slot_q[1], slot_q[2], slot_q[3]};

`ifdef AES_ROUND_CNT_EN
    localparam logic [3:0] NR = 4'(NR_128);

    // Holds the round number of the block that will next be presented.
    logic [3:0] round_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_q <= 4'd1;
        end else if (out_acc) begin
            round_q <= (round_q == NR) ? 4'd1 : round_q + 4'd1;
        end
    end

    assign bus.o_Round = (state_q == FULL) ? round_q : 4'd0;
    assign bus.o_Last  = (state_q == FULL) && (round_q == NR);
`else
    assign bus.o_Round = 4'd0;
    assign bus.o_Last  = 1'b0;
`endif

endmodule

// File: tb/tb_round_key_add_col.sv
// Randomized and directed bench for round_key_add_col with a queue scoreboard.
module tb_round_key_add_col;
    import aes_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    round_key_add_col_if bus ();

    round_key_add_col dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    state_t q_exp[$];
    col_t   part[4];
    int     cnt;
    state_t kcap;
    logic   pending;
    int     hs_cnt;

    localparam state_t FIPS_KEY = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam state_t FIPS_RES = 128'ha49c7ff2_689f352b_6b5bea43_026a5049;
    localparam state_t ID_RES   = 128'h11223344_5566778899aabbcc_ddeeff00;

    col_t fips_col[4];
    col_t id_col[4];

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic col_t kword(input state_t k, input int i);
        return col_t'(k >> (32 * (3 - i)));
    endfunction

    task automatic model_reset();
        q_exp.delete();
        cnt     = 0;
        pending = 1'b0;
        hs_cnt  = 0;
    endtask

    task automatic step(input logic v, input col_t d, input state_t k,
                        input logic r);
        logic [3:0] exp_r;
        state_t     e;
        bus.i_Col_Valid = v;
        bus.i_Col_Data  = d;
        bus.i_Round_Key = k;
        bus.i_Ready     = r;
        @(negedge clk);
`ifdef AES_ROUND_CNT_EN
        exp_r = pending ? 4'((hs_cnt % NR_128) + 1) : 4'd0;
`else
        exp_r = 4'd0;
`endif
        check("valid", 128'(bus.o_Valid), 128'(pending));
        check("col_ready", 128'(bus.o_Col_Ready), 128'(!pending || r));
        check("round", 128'(bus.o_Round), 128'(exp_r));
        check("last", 128'(bus.o_Last), 128'(exp_r == 4'd10));
        if (bus.o_Valid && r) begin
            if (q_exp.size() == 0) begin
                check("unexpected_out", 128'(1), 128'(0));
            end else begin
                e = q_exp.pop_front();
                check("data", bus.o_Data, e);
            end
            hs_cnt++;
            pending = 1'b0;
        end
        if (v && bus.o_Col_Ready) begin
            if (cnt == 0) kcap = k;
            part[cnt] = d ^ kword(kcap, cnt);
            cnt++;
            if (cnt == 4) begin
                q_exp.push_back({part[0], part[1], part[2], part[3]});
                cnt     = 0;
                pending = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic state_t rnd_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        n_chk = 0;
        n_err = 0;
        kcap  = '0;
        fips_col[0] = 32'h046681e5;
        fips_col[1] = 32'he0cb199a;
        fips_col[2] = 32'h48f8d37a;
        fips_col[3] = 32'h2806264c;
        id_col[0]   = 32'h11223344;
        id_col[1]   = 32'h55667788;
        id_col[2]   = 32'h99aabbcc;
        id_col[3]   = 32'hddeeff00;
        bus.i_Col_Valid = 1'b0;
        bus.i_Col_Data  = '0;
        bus.i_Round_Key = '0;
        bus.i_Ready     = 1'b0;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(bus.o_Valid), 128'(0));
        check("rst_data", bus.o_Data, 128'(0));
        check("rst_round", 128'(bus.o_Round), 128'(0));
        check("rst_last", 128'(bus.o_Last), 128'(0));
        check("rst_col_ready", 128'(bus.o_Col_Ready), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 128'(bus.o_Col_Ready), 128'(1));

        // FIPS-197 round 1 AddRoundKey
        for (int i = 0; i < 4; i++) step(1'b1, fips_col[i], FIPS_KEY, 1'b0);
        check("fips_valid", 128'(bus.o_Valid), 128'(1));
        check("fips_data", bus.o_Data, FIPS_RES);

        // Backpressure with a column offered but refused
        for (int i = 0; i < 5; i++) begin
            step(1'b1, id_col[0], '0, 1'b0);
            check("bp_stable", bus.o_Data, FIPS_RES);
        end
        step(1'b1, id_col[0], '0, 1'b1);
        for (int i = 1; i < 4; i++) step(1'b1, id_col[i], rnd_key(), 1'b0);
        check("ident_data", bus.o_Data, ID_RES);
        step(1'b0, '0, '0, 1'b1);

        // Gapped input with the key changing during the gap
        step(1'b1, fips_col[0], FIPS_KEY, 1'b0);
        step(1'b1, fips_col[1], FIPS_KEY, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, $urandom, rnd_key(), 1'b0);
        step(1'b1, fips_col[2], rnd_key(), 1'b0);
        step(1'b1, fips_col[3], rnd_key(), 1'b0);
        check("gap_data", bus.o_Data, FIPS_RES);
        step(1'b0, '0, '0, 1'b1);

        // Reset after column 2 of a block
        for (int i = 0; i < 3; i++) step(1'b1, id_col[i], rnd_key(), 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 128'(bus.o_Valid), 128'(0));
        check("midrst_data", bus.o_Data, 128'(0));
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, fips_col[i], FIPS_KEY, 1'b0);
        check("after_rst_data", bus.o_Data, FIPS_RES);
        step(1'b0, '0, '0, 1'b1);

        // Eleven back-to-back blocks from reset
        do_reset();
        for (int b = 0; b < 11; b++) begin
            state_t k;
            k = rnd_key();
            for (int i = 0; i < 4; i++) step(1'b1, $urandom, k, 1'b1);
        end
        step(1'b0, '0, '0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom, rnd_key(), ($urandom % 3) != 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1);
        check("queue_empty", 128'(q_exp.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
